// File: rtl/usb_seg_pkg.sv
// Shared definitions for the USB segment router: direction codes, FSM states,
// status flag positions, response magic and the identification fingerprint.
package usb_seg_pkg;

    localparam logic [3:0] DIR_FP    = 4'h0;
    localparam logic [3:0] DIR_IN    = 4'h4;
    localparam logic [3:0] DIR_OUT   = 4'h8;
    localparam logic [3:0] DIR_ABORT = 4'hF;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        XFER_IN  = 3'd1,
        XFER_OUT = 3'd2,
        RESP0    = 3'd3,
        RESP1    = 3'd4
    } state_e;

    localparam int FLAG_BAD   = 0;
    localparam int FLAG_ABORT = 1;
    localparam int FLAG_TRUNC = 2;

    localparam logic [7:0]  RESP_MAGIC  = 8'hA5;
    localparam logic [63:0] FINGERPRINT = 64'h4742_4120_492F_4F0A;
    localparam int          CNT_W       = 32;

    // Host reads the fingerprint little-endian, so each word goes out byte-reversed.
    function automatic logic [31:0] byte_rev32(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/usb_seg_router_if.sv
// Bundle of the ctrl/resp/tx/rx streams and the memory mux port.
// slave = router side, master = host/memory environment side.
interface usb_seg_router_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 26
);
    logic [31:0]       ctrl_tdata;
    logic              ctrl_tvalid;
    logic              ctrl_tready;
    logic [31:0]       resp_tdata;
    logic              resp_tvalid;
    logic              resp_tlast;
    logic              resp_tready;
    logic [DATA_W-1:0] tx_tdata;
    logic              tx_tvalid;
    logic              tx_tready;
    logic [DATA_W-1:0] rx_tdata;
    logic              rx_tvalid;
    logic              rx_tlast;
    logic              rx_tready;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_wr;
    logic [DATA_W-1:0] mem_wr_data;
    logic              mem_wr_ready;
    logic              mem_rd;
    logic [DATA_W-1:0] mem_rd_data;
    logic              mem_rd_valid;
    logic              mem_rd_ready;

    modport slave (
        input  ctrl_tdata, ctrl_tvalid, output ctrl_tready,
        output resp_tdata, resp_tvalid, resp_tlast, input resp_tready,
        input  tx_tdata, tx_tvalid, output tx_tready,
        output rx_tdata, rx_tvalid, rx_tlast, input rx_tready,
        output mem_addr, mem_wr, mem_wr_data, input mem_wr_ready,
        output mem_rd, input mem_rd_data, mem_rd_valid, mem_rd_ready
    );

    modport master (
        output ctrl_tdata, ctrl_tvalid, input ctrl_tready,
        input  resp_tdata, resp_tvalid, resp_tlast, output resp_tready,
        output tx_tdata, tx_tvalid, input tx_tready,
        input  rx_tdata, rx_tvalid, rx_tlast, output rx_tready,
        input  mem_addr, mem_wr, mem_wr_data, output mem_wr_ready,
        input  mem_rd, output mem_rd_data, mem_rd_valid, mem_rd_ready
    );
endinterface

// File: rtl/usb_seg_resp.sv
// Two-word response serializer: load captures both words, word1 carries tlast,
// done pulses when word1 is accepted.
module usb_seg_resp (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_i,
    input  logic [31:0] word0_i,
    input  logic [31:0] word1_i,
    output logic [31:0] resp_tdata_o,
    output logic        resp_tvalid_o,
    output logic        resp_tlast_o,
    input  logic        resp_tready_i,
    output logic        done_o
);
    logic        valid_q, valid_d;
    logic        sel_q, sel_d;
    logic [31:0] w0_q, w0_d;
    logic [31:0] w1_q, w1_d;
    logic        fire_s;

    assign fire_s        = valid_q & resp_tready_i;
    assign resp_tvalid_o = valid_q;
    assign resp_tlast_o  = valid_q & sel_q;
    assign resp_tdata_o  = valid_q ? (sel_q ? w1_q : w0_q) : 32'h0000_0000;
    assign done_o        = fire_s & sel_q;

    // Next-state for the word holders and the word-select phase.
    always_comb begin
        valid_d = valid_q;
        sel_d   = sel_q;
        w0_d    = w0_q;
        w1_d    = w1_q;
        if (load_i) begin
            valid_d = 1'b1;
            sel_d   = 1'b0;
            w0_d    = word0_i;
            w1_d    = word1_i;
        end else if (fire_s) begin
            valid_d = ~sel_q;
            sel_d   = ~sel_q;
        end else begin
            valid_d = valid_q;
        end
    end

    // Serializer registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            sel_q   <= 1'b0;
            w0_q    <= 32'h0000_0000;
            w1_q    <= 32'h0000_0000;
        end else begin
            valid_q <= valid_d;
            sel_q   <= sel_d;
            w0_q    <= w0_d;
            w1_q    <= w1_d;
        end
    end
endmodule

// File: rtl/usb_seg_router.sv
// USB command router: decodes host commands, streams data between host and a
// table-driven memory segment, and answers every command with a two-word status.
// Optional feature macro: USB_SEG_ROUTER_ABORT_EN (dir=0xF aborts a running transfer).
module usb_seg_router
    import usb_seg_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 26,
    parameter int NUM_SEG = 8,
    parameter logic [NUM_SEG*ADDR_W-1:0] SEG_BASE = {
        ADDR_W'(32'h0000_2000), ADDR_W'(32'h0000_1000), ADDR_W'(32'h0000_0800), ADDR_W'(32'h0000_0400),
        ADDR_W'(32'h0000_0200), ADDR_W'(32'h0000_0100), ADDR_W'(32'h0000_0000), ADDR_W'(32'h0000_0000)},
    parameter logic [NUM_SEG*ADDR_W-1:0] SEG_SIZE = {
        ADDR_W'(32'h0000_1000), ADDR_W'(32'h0000_0800), ADDR_W'(32'h0000_0400), ADDR_W'(32'h0000_0100),
        ADDR_W'(32'h0000_0020), ADDR_W'(32'h0000_0010), ADDR_W'(32'h0000_0010), ADDR_W'(32'h0000_0000)},
    parameter int LED_HOLD = 1000000
) (
    input  logic             clk,
    input  logic             rst,
    usb_seg_router_if.slave  bus,
    output logic             busy,
    output logic             led_act
);
    localparam int BSH   = $clog2(DATA_W / 8);
    localparam int LED_W = (LED_HOLD > 1) ? $clog2(LED_HOLD + 1) : 1;
    localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(DATA_W / 8);

    state_e             state_q, state_d;
    logic [3:0]         seg_q, seg_d;
    logic [3:0]         dir_q, dir_d;
    logic               fp_q, fp_d;
    logic [7:0]         flags_q, flags_d;
    logic [ADDR_W-1:0]  offset_q, offset_d;
    logic [CNT_W-1:0]   remaining_q, remaining_d;
    logic [CNT_W-1:0]   done_q, done_d;
    logic [LED_W-1:0]   led_q, led_d;

    logic [ADDR_W-1:0]  base_a [16];
    logic [ADDR_W-1:0]  size_a [16];
    logic [3:0]         cmd_seg_s, cmd_dir_s;
    logic [23:0]        cmd_n_s;
    logic               seg_ok_s, trunc_s;
    logic [CNT_W-1:0]   size_words_s, req_words_s, rem_words_s;
    logic               in_s, out_s, ctrl_ready_s, ctrl_fire_s, beat_s;
    logic               resp_load_s, resp_done_s;
    logic [31:0]        word0_s, word1_s;

    // Unused table slots read as an empty segment so a 4-bit index is always safe.
    for (genvar i = 0; i < 16; i++) begin : g_tab
        if (i < NUM_SEG) begin : g_used
            assign base_a[i] = SEG_BASE[i*ADDR_W +: ADDR_W];
            assign size_a[i] = SEG_SIZE[i*ADDR_W +: ADDR_W];
        end else begin : g_empty
            assign base_a[i] = '0;
            assign size_a[i] = '0;
        end
    end

    assign in_s  = (state_q == XFER_IN);
    assign out_s = (state_q == XFER_OUT);
`ifdef USB_SEG_ROUTER_ABORT_EN
    assign ctrl_ready_s = ~rst & ((state_q == IDLE) | in_s | out_s);
`else
    assign ctrl_ready_s = ~rst & (state_q == IDLE);
`endif
    assign ctrl_fire_s     = bus.ctrl_tvalid & ctrl_ready_s;
    assign bus.ctrl_tready = ctrl_ready_s;

    assign bus.tx_tready   = out_s & bus.mem_wr_ready;
    assign bus.mem_wr      = bus.tx_tready & bus.tx_tvalid;
    assign bus.mem_wr_data = bus.mem_wr ? bus.tx_tdata : '0;
    assign bus.rx_tvalid   = in_s & bus.mem_rd_valid & bus.mem_rd_ready;
    assign bus.rx_tdata    = bus.rx_tvalid ? bus.mem_rd_data : '0;
    assign bus.mem_rd      = bus.rx_tvalid & bus.rx_tready;
    assign bus.rx_tlast    = bus.rx_tvalid & (remaining_q == CNT_W'(1));
    assign bus.mem_addr    = (in_s | out_s) ? (base_a[seg_q] + offset_q) : '0;
    assign beat_s          = bus.mem_wr | bus.mem_rd;
    assign busy            = (state_q != IDLE);
    assign led_act         = (led_q != '0);

    // Decode of the command word currently offered on the ctrl stream.
    always_comb begin
        cmd_seg_s    = bus.ctrl_tdata[3:0];
        cmd_dir_s    = bus.ctrl_tdata[7:4];
        cmd_n_s      = bus.ctrl_tdata[31:8];
        seg_ok_s     = (cmd_seg_s != 4'd0) && (int'(cmd_seg_s) < NUM_SEG);
        size_words_s = CNT_W'(size_a[cmd_seg_s] >> BSH);
        req_words_s  = (cmd_n_s == 24'd0) ? size_words_s : CNT_W'(cmd_n_s);
        trunc_s      = (req_words_s > size_words_s);
        rem_words_s  = trunc_s ? size_words_s : req_words_s;
    end

    // Transfer FSM next-state and bookkeeping.
    always_comb begin
        state_d     = state_q;
        seg_d       = seg_q;
        dir_d       = dir_q;
        fp_d        = fp_q;
        flags_d     = flags_q;
        offset_d    = offset_q;
        remaining_d = remaining_q;
        done_d      = done_q;
        case (state_q)
            IDLE: begin
                if (ctrl_fire_s) begin
                    seg_d       = cmd_seg_s;
                    dir_d       = cmd_dir_s;
                    fp_d        = 1'b0;
                    flags_d     = 8'h00;
                    offset_d    = '0;
                    done_d      = '0;
                    remaining_d = '0;
                    if (cmd_dir_s == DIR_FP) begin
                        fp_d    = 1'b1;
                        state_d = RESP0;
                    end else if (!seg_ok_s || (cmd_dir_s != DIR_IN && cmd_dir_s != DIR_OUT)) begin
                        flags_d[FLAG_BAD] = 1'b1;
                        state_d           = RESP0;
                    end else begin
                        remaining_d         = rem_words_s;
                        flags_d[FLAG_TRUNC] = trunc_s;
                        // An empty segment has nothing to move; answer at once.
                        if (rem_words_s == '0) begin
                            state_d = RESP0;
                        end else begin
                            state_d = (cmd_dir_s == DIR_IN) ? XFER_IN : XFER_OUT;
                        end
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            XFER_IN, XFER_OUT: begin
                if (beat_s) begin
                    offset_d    = offset_q + STRIDE;
                    remaining_d = remaining_q - CNT_W'(1);
                    done_d      = done_q + CNT_W'(1);
                    state_d     = (remaining_q == CNT_W'(1)) ? RESP0 : state_q;
                end else begin
                    state_d = state_q;
                end
`ifdef USB_SEG_ROUTER_ABORT_EN
                if (ctrl_fire_s && cmd_dir_s == DIR_ABORT) begin
                    flags_d[FLAG_ABORT] = 1'b1;
                    state_d             = RESP0;
                end else begin
                    flags_d[FLAG_ABORT] = flags_q[FLAG_ABORT];
                end
`endif
            end
            RESP0:   state_d = (bus.resp_tvalid & bus.resp_tready) ? RESP1 : RESP0;
            RESP1:   state_d = resp_done_s ? IDLE : RESP1;
            default: state_d = IDLE;
        endcase
    end

    // Status words are built from next-state values so they load on the RESP0 entry edge.
    always_comb begin
        resp_load_s = (state_d == RESP0) && (state_q != RESP0);
        if (fp_d) begin
            word0_s = byte_rev32(FINGERPRINT[63:32]);
            word1_s = byte_rev32(FINGERPRINT[31:0]);
        end else begin
            word0_s = {RESP_MAGIC, flags_d, 8'h00, dir_d, seg_d};
            word1_s = done_d;
        end
    end

    // Activity LED stretch counter.
    always_comb begin
        if ((state_d == XFER_IN || state_d == XFER_OUT) && !(in_s || out_s)) begin
            led_d = LED_W'(LED_HOLD);
        end else if (led_q != '0) begin
            led_d = led_q - LED_W'(1);
        end else begin
            led_d = led_q;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            seg_q       <= 4'h0;
            dir_q       <= 4'h0;
            fp_q        <= 1'b0;
            flags_q     <= 8'h00;
            offset_q    <= '0;
            remaining_q <= '0;
            done_q      <= '0;
            led_q       <= '0;
        end else begin
            state_q     <= state_d;
            seg_q       <= seg_d;
            dir_q       <= dir_d;
            fp_q        <= fp_d;
            flags_q     <= flags_d;
            offset_q    <= offset_d;
            remaining_q <= remaining_d;
            done_q      <= done_d;
            led_q       <= led_d;
        end
    end

    usb_seg_resp u_resp (
        .clk           (clk),
        .rst           (rst),
        .load_i        (resp_load_s),
        .word0_i       (word0_s),
        .word1_i       (word1_s),
        .resp_tdata_o  (bus.resp_tdata),
        .resp_tvalid_o (bus.resp_tvalid),
        .resp_tlast_o  (bus.resp_tlast),
        .resp_tready_i (bus.resp_tready),
        .done_o        (resp_done_s)
    );
endmodule

// File: tb/tb_usb_seg_router.sv
// Directed bench for usb_seg_router with a queue scoreboard for resp, mem write and rx beats.
module tb_usb_seg_router;
    logic clk = 1'b0;
    logic rst;
    logic busy, led_act;
    int   checks = 0;
    int   errors = 0;
    logic [63:0] resp_q[$];
    logic [63:0] wr_q[$];
    logic [63:0] rx_q[$];
    logic [63:0] mon_exp;

    usb_seg_router_if #(.DATA_W(32), .ADDR_W(26)) bus ();

    usb_seg_router #(.LED_HOLD(16)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .busy    (busy),
        .led_act (led_act)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rd_model(input logic [25:0] a);
        return {6'h00, a} ^ 32'hC0DE_0000;
    endfunction

    function automatic logic [63:0] rw(input logic last, input logic [31:0] d);
        return {31'h0, last, d};
    endfunction

    assign bus.mem_rd_data = rd_model(bus.mem_addr);

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every handshake is compared with the oldest expected entry.
    always @(negedge clk) begin
        if (bus.resp_tvalid && bus.resp_tready) begin
            checks++;
            assert (resp_q.size() != 0) else begin
                errors++;
                $error("FAIL resp_extra observed=%h expected=none", bus.resp_tdata);
            end
            if (resp_q.size() != 0) begin
                mon_exp = resp_q.pop_front();
                chk("resp_word", rw(bus.resp_tlast, bus.resp_tdata), mon_exp);
            end
        end
        if (bus.mem_wr) begin
            checks++;
            assert (wr_q.size() != 0) else begin
                errors++;
                $error("FAIL wr_extra observed=%h expected=none", bus.mem_addr);
            end
            if (wr_q.size() != 0) begin
                mon_exp = wr_q.pop_front();
                chk("mem_write", {6'h00, bus.mem_addr, bus.mem_wr_data}, mon_exp);
            end
        end
        if (bus.rx_tvalid) begin
            chk("mem_rd_strobe", bus.mem_rd, bus.rx_tready);
        end
        if (bus.rx_tvalid && bus.rx_tready) begin
            checks++;
            assert (rx_q.size() != 0) else begin
                errors++;
                $error("FAIL rx_extra observed=%h expected=none", bus.rx_tdata);
            end
            if (rx_q.size() != 0) begin
                mon_exp = rx_q.pop_front();
                chk("rx_word", rw(bus.rx_tlast, bus.rx_tdata), mon_exp);
            end
        end
    end

    task automatic send_cmd(input logic [31:0] c);
        int n = 0;
        bus.ctrl_tdata  = c;
        bus.ctrl_tvalid = 1'b1;
        while (!bus.ctrl_tready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("ctrl_accept", bus.ctrl_tready, 1'b1);
        @(posedge clk); #1;
        bus.ctrl_tvalid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk(tag, busy, 1'b0);
    endtask

    task automatic out_xfer(input logic [31:0] base, input int beats, input int stall_at, input logic [31:0] salt);
        int k = 0;
        for (int c = 0; k < beats && c < 64; c++) begin
            bus.tx_tvalid = 1'b1;
            bus.tx_tdata  = salt + 32'(k);
            if (c == stall_at) begin
                bus.mem_wr_ready = 1'b0;
                #1;
                chk("out_stall_tready", bus.tx_tready, 1'b0);
                chk("out_stall_wr", bus.mem_wr, 1'b0);
            end else begin
                bus.mem_wr_ready = 1'b1;
                wr_q.push_back({base + 32'(4 * k), salt + 32'(k)});
                k++;
            end
            @(posedge clk); #1;
        end
        bus.tx_tvalid    = 1'b0;
        bus.mem_wr_ready = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst              = 1'b1;
        bus.ctrl_tdata   = 32'h0;
        bus.ctrl_tvalid  = 1'b0;
        bus.resp_tready  = 1'b1;
        bus.tx_tdata     = 32'h0;
        bus.tx_tvalid    = 1'b0;
        bus.rx_tready    = 1'b1;
        bus.mem_wr_ready = 1'b1;
        bus.mem_rd_valid = 1'b1;
        bus.mem_rd_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ctrl_tready", bus.ctrl_tready, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_resp_tvalid", bus.resp_tvalid, 1'b0);
        chk("rst_led", led_act, 1'b0);
        chk("rst_mem_addr", bus.mem_addr, 26'h0);
        rst = 1'b0;
        #1;
        chk("idle_ctrl_tready", bus.ctrl_tready, 1'b1);

        // Fingerprint, with the host stalling the first response word.
        resp_q.push_back(rw(1'b0, 32'h2041_4247));
        resp_q.push_back(rw(1'b1, 32'h0A4F_2F49));
        bus.resp_tready = 1'b0;
        send_cmd(32'h0000_0000);
        chk("fp_valid", bus.resp_tvalid, 1'b1);
        chk("fp_word0", bus.resp_tdata, 32'h2041_4247);
        repeat (2) @(posedge clk);
        #1;
        chk("fp_hold_valid", bus.resp_tvalid, 1'b1);
        chk("fp_hold_word0", bus.resp_tdata, 32'h2041_4247);
        bus.resp_tready = 1'b1;
        wait_idle("fp_idle");
        chk("fp_no_led", led_act, 1'b0);

        // OUT to seg 1, whole segment, one write-port stall.
        resp_q.push_back(rw(1'b0, 32'hA500_0081));
        resp_q.push_back(rw(1'b1, 32'h0000_0004));
        send_cmd(32'h0000_0081);
        chk("out_busy", busy, 1'b1);
        chk("out_addr0", bus.mem_addr, 26'h0);
        chk("out_led", led_act, 1'b1);
`ifdef USB_SEG_ROUTER_ABORT_EN
        chk("out_ctrl_tready", bus.ctrl_tready, 1'b1);
`else
        chk("out_ctrl_tready", bus.ctrl_tready, 1'b0);
`endif
        out_xfer(32'h0000_0000, 4, 2, 32'h1111_0000);
        wait_idle("out_idle");
        repeat (16) @(posedge clk);
        #1;
        chk("led_expired", led_act, 1'b0);

        // IN from seg 2, three words, rx_tready toggling every cycle.
        for (int i = 0; i < 3; i++) begin
            rx_q.push_back(rw(i == 2, rd_model(26'(32'h100 + 4 * i))));
        end
        resp_q.push_back(rw(1'b0, 32'hA500_0042));
        resp_q.push_back(rw(1'b1, 32'h0000_0003));
        bus.rx_tready = 1'b0;
        send_cmd(32'h0000_0342);
        chk("in_addr0", bus.mem_addr, 26'h100);
        chk("in_rx_tvalid", bus.rx_tvalid, 1'b1);
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            bus.rx_tready = ~bus.rx_tready;
        end
        bus.rx_tready = 1'b1;
        wait_idle("in_idle");

        // Truncation: N=0x100 on a 16-byte segment.
        resp_q.push_back(rw(1'b0, 32'hA504_0081));
        resp_q.push_back(rw(1'b1, 32'h0000_0004));
        send_cmd(32'h0001_0081);
        out_xfer(32'h0000_0000, 4, -1, 32'h2222_0000);
        wait_idle("trunc_idle");

        // Bad segment, out-of-table segment, bad direction.
        resp_q.push_back(rw(1'b0, 32'hA501_0040));
        resp_q.push_back(rw(1'b1, 32'h0000_0000));
        send_cmd(32'h0000_0040);
        chk("bad_addr", bus.mem_addr, 26'h0);
        chk("bad_tx_tready", bus.tx_tready, 1'b0);
        chk("bad_rx_tvalid", bus.rx_tvalid, 1'b0);
        wait_idle("bad_idle");
        resp_q.push_back(rw(1'b0, 32'hA501_0048));
        resp_q.push_back(rw(1'b1, 32'h0000_0000));
        send_cmd(32'h0000_0048);
        wait_idle("badseg_idle");
        resp_q.push_back(rw(1'b0, 32'hA501_00F1));
        resp_q.push_back(rw(1'b1, 32'h0000_0000));
        send_cmd(32'h0000_00F1);
        wait_idle("baddir_idle");

`ifdef USB_SEG_ROUTER_ABORT_EN
        // Abort after 2 of 8 beats on seg 3.
        resp_q.push_back(rw(1'b0, 32'hA502_0083));
        resp_q.push_back(rw(1'b1, 32'h0000_0002));
        send_cmd(32'h0000_0083);
        out_xfer(32'h0000_0200, 2, -1, 32'h3333_0000);
        send_cmd(32'h0000_00F0);
        wait_idle("abort_idle");
`endif

        // Reset in the middle of an IN transfer on seg 4.
        rx_q.push_back(rw(1'b0, rd_model(26'h400)));
        send_cmd(32'h0000_0044);
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("rst_mid_rx_tvalid", bus.rx_tvalid, 1'b0);
        chk("rst_mid_mem_rd", bus.mem_rd, 1'b0);
        chk("rst_mid_addr", bus.mem_addr, 26'h0);
        chk("rst_mid_busy", busy, 1'b0);
        chk("rst_mid_ctrl_tready", bus.ctrl_tready, 1'b0);
        chk("rst_mid_resp_tvalid", bus.resp_tvalid, 1'b0);
        chk("rst_mid_led", led_act, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("post_rst_ctrl_tready", bus.ctrl_tready, 1'b1);
        chk("post_rst_busy", busy, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        resp_q.push_back(rw(1'b0, 32'h2041_4247));
        resp_q.push_back(rw(1'b1, 32'h0A4F_2F49));
        send_cmd(32'h0000_0000);
        wait_idle("post_rst_fp_idle");

        repeat (2) @(posedge clk);
        #1;
        chk("resp_q_drained", resp_q.size(), 0);
        chk("wr_q_drained", wr_q.size(), 0);
        chk("rx_q_drained", rx_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
